// File: rtl/bus_router_if.sv
// bus_router_if: cpu-side request/response and per-slave fan-out signals of the bus router.
interface bus_router_if #(
  parameter int NUM_SLAVES = 3
);
  logic                    memory_valid;
  logic                    memory_instr;
  logic [31:0]             memory_addr;
  logic [31:0]             memory_wdata;
  logic [3:0]              memory_wstrb;
  logic [31:0]             memory_rdata;
  logic                    memory_ready;
  logic                    memory_error;
  logic [NUM_SLAVES-1:0]   slave_valid;
  logic                    slave_instr;
  logic [31:0]             slave_wdata;
  logic [3:0]              slave_wstrb;
  logic [NUM_SLAVES*32-1:0] slave_addr;
  logic [NUM_SLAVES*32-1:0] slave_rdata;
  logic [NUM_SLAVES-1:0]   slave_ready;
  logic [7:0]              err_count;
  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, slave_rdata, slave_ready,
    input  memory_rdata, memory_ready, memory_error, slave_valid, slave_instr, slave_wdata, slave_wstrb,
           slave_addr, err_count
  );
  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb, slave_rdata, slave_ready,
    output memory_rdata, memory_ready, memory_error, slave_valid, slave_instr, slave_wdata, slave_wstrb,
           slave_addr, err_count
  );
endinterface

// File: rtl/bus_router.sv
// bus_router: decodes cpu requests onto address-windowed slaves, one outstanding transaction, with timeout/error responses.
module bus_router #(
  parameter int NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0020_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_TOP  = {32'h0020_0010, 32'h0010_0004, 32'h0010_0000},
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  bus_router_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] sel, sel_n, idx;
  logic hit;
  logic [7:0] err_cnt;
  assign bus.slave_instr = bus.memory_instr;
  assign bus.slave_wdata = bus.memory_wdata;
  assign bus.slave_wstrb = bus.memory_wstrb;
  assign bus.err_count   = err_cnt;
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_addr
    assign bus.slave_addr[32*g +: 32] = bus.memory_addr - SLAVE_BASE[32*g +: 32];
  end
  // Scan downward so the lowest hitting window wins; base >= top can never match.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (bus.memory_addr >= SLAVE_BASE[32*i +: 32] && bus.memory_addr < SLAVE_TOP[32*i +: 32]) begin
        hit = 1'b1;
        idx = SW'(i);
      end
  end
  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    sel_n            = sel;
    bus.slave_valid  = '0;
    bus.memory_ready = 1'b0;
    bus.memory_error = 1'b0;
    bus.memory_rdata = '0;
    if (!rst)
      case (state)
        IDLE: if (bus.memory_valid) begin
          if (hit) begin
            bus.slave_valid[idx] = 1'b1;
            if (bus.slave_ready[idx]) begin
              bus.memory_ready = 1'b1;
              bus.memory_rdata = bus.slave_rdata[32*idx +: 32];
            end else begin
              sel_n   = idx;
              cnt_n   = CW'(1);
              state_n = WAIT;
            end
          end else state_n = ERR;
        end
        WAIT: if (bus.slave_ready[sel]) begin
          bus.memory_ready = 1'b1;
          bus.memory_rdata = bus.slave_rdata[32*sel +: 32];
          state_n          = IDLE;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
          bus.memory_ready = 1'b1;
          bus.memory_error = 1'b1;
          state_n          = IDLE;
        end else cnt_n = cnt + 1'b1;
        default: begin
          bus.memory_ready = 1'b1;
          bus.memory_error = 1'b1;
          state_n          = IDLE;
        end
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      if (bus.memory_ready && bus.memory_error && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
endmodule

// File: tb/tb_bus_router.sv
// tb_bus_router: randomized and directed transactions checked against a transaction-level outcome model.
module tb_bus_router;
  localparam int N  = 3;
  localparam int TO = 4;
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h0010_0000, 32'h0020_0000};
  localparam logic [31:0] TOP  [N] = '{32'h0010_0000, 32'h0010_0004, 32'h0020_0010};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int errs  = 0;
  bus_router_if #(.NUM_SLAVES(N)) bus ();
  bus_router #(.NUM_SLAVES(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) if (a >= BASE[i] && a < TOP[i]) return i;
    return -1;
  endfunction
  task automatic idle_inputs();
    bus.memory_valid = 1'b0;
    bus.memory_instr = 1'b0;
    bus.memory_addr  = '0;
    bus.memory_wdata = '0;
    bus.memory_wstrb = '0;
    bus.slave_ready  = '0;
    bus.slave_rdata  = '0;
  endtask
  // One transaction: the outcome (who answers, in which cycle, with what) follows from the address rules alone.
  task automatic txn(input logic [31:0] a, input int lat, input int spur_c, input int spur_s);
    int idx, ec;
    logic eerr, ins;
    logic [31:0] wd, erd;
    logic [3:0] ws;
    idx  = decode(a);
    eerr = (idx < 0) || (lat > TO);
    ec   = (idx < 0) ? 1 : (lat > TO ? TO : lat);
    wd   = $urandom;
    ws   = 4'($urandom);
    ins  = 1'($urandom);
    for (int c = 0; c <= ec; c++) begin
      bus.slave_rdata = {$urandom, $urandom, $urandom};
      bus.slave_ready = '0;
      if (idx >= 0 && c == lat) bus.slave_ready[idx] = 1'b1;
      if (c == spur_c && spur_s != idx) bus.slave_ready[spur_s] = 1'b1;
      bus.memory_valid = (c == 0) ? 1'b1 : 1'($urandom);
      bus.memory_addr  = (c == 0) ? a : 32'($urandom_range(0, 32'h0020_000F));
      bus.memory_wdata = wd;
      bus.memory_wstrb = ws;
      bus.memory_instr = ins;
      erd = (c == ec && !eerr) ? bus.slave_rdata[32*idx +: 32] : 32'h0;
      #2;
      check("slave_valid", 32'(bus.slave_valid), (c == 0 && idx >= 0) ? (32'd1 << idx) : 32'd0);
      if (c == 0 && idx >= 0) begin
        check("slave_addr", bus.slave_addr[32*idx +: 32], a - BASE[idx]);
        check("slave_wdata", bus.slave_wdata, wd);
        check("slave_wstrb", 32'(bus.slave_wstrb), 32'(ws));
        check("slave_instr", 32'(bus.slave_instr), 32'(ins));
      end
      check("memory_ready", 32'(bus.memory_ready), 32'(c == ec));
      check("memory_error", 32'(bus.memory_error), 32'(c == ec && eerr));
      check("memory_rdata", bus.memory_rdata, erd);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    if (eerr && errs < 255) errs++;
    check("err_count", 32'(bus.err_count), 32'(errs));
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 32'h000F_FFFF));
      1: return 32'h0010_0000 + 32'($urandom_range(0, 5));
      2: return 32'h0020_0000 + 32'($urandom_range(0, 17));
      3: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    idle_inputs();
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h40;
    bus.slave_ready  = '1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_ready", 32'(bus.memory_ready), 32'd0);
    check("rst_error", 32'(bus.memory_error), 32'd0);
    check("rst_rdata", bus.memory_rdata, 32'd0);
    check("rst_slave_valid", 32'(bus.slave_valid), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    txn(32'h0000_0040, 0, -1, 0);
    txn(32'h0010_0000, 3, -1, 0);
    txn(32'h0000_1000, 3, 2, 2);
    txn(32'h0030_0000, 0, -1, 0);
    txn(32'h0010_0000, 9, -1, 0);
    txn(32'h0010_0003, TO, 1, 0);
    txn(32'h0010_0004, 0, -1, 0);
    txn(32'h000F_FFFF, 1, -1, 0);
    txn(32'h0020_000F, 2, 1, 1);
    txn(32'h0020_0010, 0, -1, 0);
    for (int i = 0; i < 200; i++)
      txn(rand_addr(), int'($urandom_range(0, TO + 2)), int'($urandom_range(0, TO)), int'($urandom_range(0, N - 1)));
    for (int i = 0; i < 300; i++) txn(32'h0010_0001, TO + 1, -1, 0);
    bus.memory_valid = 1'b1;
    bus.memory_addr  = 32'h40;
    #2;
    check("rr_slave_valid", 32'(bus.slave_valid), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      bus.memory_valid = 1'b0;
    end
    bus.memory_valid = 1'b1;
    bus.slave_ready  = 3'b001;
    #1;
    rst = 1'b1;
    #1;
    check("rr_ready", 32'(bus.memory_ready), 32'd0);
    check("rr_error", 32'(bus.memory_error), 32'd0);
    check("rr_rdata", bus.memory_rdata, 32'd0);
    check("rr_slave_valid_rst", 32'(bus.slave_valid), 32'd0);
    check("rr_err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    errs = 0;
    idle_inputs();
    txn(32'h0000_0080, 2, -1, 0);
    txn(32'h0000_0004, 0, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bus_router.md
# bus_router

Parametrised single-master memory-bus router between `cpu` and an arbitrary number of memory-mapped slaves (bram, uart, timer, future peripherals). Decodes each request against per-slave address windows, forwards it to exactly one slave with a base-relative address, and returns only the selected slave's response. It tracks one outstanding transaction. Unmapped accesses and unresponsive slaves end in an error response, so the core never hangs.

## Interface
- `NUM_SLAVES`, 3: number of slave ports (1..16).
- `SLAVE_BASE`, {32'h0020_0000, 32'h0010_0000, 32'h0000_0000}: packed `NUM_SLAVES*32`; slave i base at bits `[32*i +: 32]`.
- `SLAVE_TOP`, {32'h0020_0010, 32'h0010_0004, 32'h0010_0000}: packed `NUM_SLAVES*32`; exclusive upper bound per slave.
- `TIMEOUT`, 255: maximum wait cycles before an error response; 0 disables the timeout.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous reset, active-high.
- `memory_valid`, `memory_instr` in 1, 1: request strobe and instruction-fetch flag.
- `memory_addr`, `memory_wdata` in 32, 32: request address and write data.
- `memory_wstrb` in 4: byte write strobes; 0 means read.
- `memory_rdata` out 32: read data to the master.
- `memory_ready` out 1: transaction complete.
- `memory_error` out 1: qualifies `memory_ready`; the access failed.
- `slave_valid` out NUM_SLAVES: one-hot request strobe.
- `slave_instr` out 1; `slave_wdata` out 32; `slave_wstrb` out 4: broadcast to all slaves.
- `slave_addr` out NUM_SLAVES*32: per-slave address, equal to `memory_addr - SLAVE_BASE[i]`.
- `slave_rdata` in NUM_SLAVES*32; `slave_ready` in NUM_SLAVES: per-slave response.
- `err_count` out 8: saturating count of error responses.

## Operation
- States: IDLE, WAIT, ERR.
- **Decode:** slave i hits when `SLAVE_BASE[i] <= memory_addr < SLAVE_TOP[i]`, unsigned. The lowest hitting index wins. A window with base >= top never hits.
- **IDLE, valid, hit i:**
  - Drive `slave_valid[i]=1` combinationally in the same cycle; all other `slave_valid` bits stay 0.
  - If `slave_ready[i]` is high in the same cycle, complete immediately and stay in IDLE.
  - Otherwise latch i into `sel`, load `cnt=1` and go to WAIT.
- **IDLE, valid, no hit:** no `slave_valid` is asserted; go to ERR.
- **WAIT:**
  - `slave_valid` is all zero. `slave_valid` is a single-cycle pulse per transaction.
  - `memory_valid` is ignored; there is no new request acceptance.
  - `slave_ready[sel]` completes the transaction and returns to IDLE. Ready from any other slave is ignored.
  - Otherwise, if `TIMEOUT != 0` and `cnt == TIMEOUT`, issue an error response and return to IDLE.
  - Otherwise increment `cnt`.
- **ERR:** for one cycle drive `memory_ready=1`, `memory_error=1`, `memory_rdata=0`, then go to IDLE.
- **Response mux:** `memory_rdata = slave_rdata[sel]` on a normal completion, else 0. `memory_error=0` on a normal completion.
- **err_count:** +1 on each error response; saturates at 255.
- **Widths:** `cnt` is `max(1, $clog2(TIMEOUT+1))` bits. The address subtraction is 32-bit and discards the borrow.

## Timing
- **Reset values (while `rst` high):** state=IDLE, `cnt=0`, `sel=0`, `err_count=0`. `memory_ready`, `memory_error`, `memory_rdata` and `slave_valid` are all 0, even if `memory_valid` is high.
- **Reset mid-transaction:** the transaction is abandoned and no response is issued. After release the block accepts a new request in the first clock.
- **Latencies** (request cycle = cycle 0):
  - Zero-wait slave: ready in cycle 0.
  - Slave ready in cycle k: `memory_ready` in cycle k, combinational pass-through.
  - Unmapped address: error in cycle 1.
  - Timeout: error in cycle TIMEOUT.
- **Simultaneous `slave_ready[sel]` and `cnt == TIMEOUT`:** the normal completion wins; no error, and `err_count` is unchanged.
- **Master contract:** hold the request fields stable in cycle 0 only. Assert the next `memory_valid` no earlier than the cycle after `memory_ready`.

## Test plan
- **Zero-wait read:** `memory_valid`, addr 0x0000_0040, slave0 ready in cycle 0 with rdata 0xDEADBEEF -> `slave_valid=3'b001`, `slave_addr[0]=0x40`, ready in cycle 0, rdata 0xDEADBEEF, error 0.
- **Wait-state write:** addr 0x0010_0000, wstrb 4'hF, wdata 0x41; slave1 ready in cycle 3 -> one-cycle `slave_valid=3'b010`, `slave_addr[1]=0`, ready only in cycle 3, error 0.
- **Spurious ready:** slave2 asserts ready in cycle 2 during a slave0 WAIT -> ignored; completion comes only on `slave_ready[0]`, rdata from slave0.
- **Unmapped access:** addr 0x0030_0000 -> no `slave_valid`; cycle 1 ready=1, error=1, rdata=0; `err_count` 0 -> 1.
- **Timeout:** TIMEOUT=4, slave1 never ready -> error in cycle 4. Repeat 300 times -> `err_count` saturates at 255. Ready and `cnt == 4` in the same cycle -> normal completion.
- **Async reset:** assert `rst` in cycle 2 of a WAIT -> outputs 0 immediately, no response. After release, a new request to slave0 completes normally.
